// File: rtl/serial_tx_feeder_pkg.sv
// Shared definitions for the serial transmit feeder: FSM encoding, FIFO sizing
// defaults and the DONE resynchroniser length.
package serial_tx_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } tx_state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AW    = 4;
    localparam int SYNC_STAGES   = 2;

endpackage

// File: rtl/serial_tx_feeder_byte_fifo.sv
// Synchronous byte FIFO with registered read data and registered full/empty/count.
// Read data appears on dout after the edge that pops it (not first-word-fall-through).
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so wrapping modulo DEPTH is implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= 8'h00;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == FULL_LVL);
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/serial_tx_feeder.sv
// Byte queue feeding the UART transmitter over a four-phase SEND/DONE handshake,
// with DONE resynchronised into the system clock domain.
module serial_tx_feeder
    import serial_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [7:0]    WR_DATA,
    output logic          FULL,
    output logic          EMPTY,
    output logic [AW:0]   COUNT,
    output logic          OVERFLOW,
    output logic          BUSY,
    output logic          SEND,
    output logic [7:0]    DATA,
    input  logic          DONE
);

    // Handshake: SEND rises with DATA valid and held; the transmitter takes the
    // byte by dropping DONE, SEND then falls; DONE returning high means the byte
    // has been shifted out and a new SEND may follow.

    logic [SYNC_STAGES-1:0] done_sync;
    logic                   done_s;
    tx_state_t              state;
    tx_state_t              next_state;
    logic                   push;
    logic                   pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_sync <= '1;
        end else begin
            done_sync <= {done_sync[SYNC_STAGES-2:0], DONE};
        end
    end

    assign done_s = done_sync[SYNC_STAGES-1];

    // FULL is the registered flag, so a write in the full state is always dropped.
    assign push = WR_EN && !FULL;

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (WR_DATA),
        .pop   (pop),
        .dout  (DATA),
        .full  (FULL),
        .empty (EMPTY),
        .count (COUNT)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW <= 1'b0;
        end else begin
            OVERFLOW <= WR_EN && FULL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (!EMPTY && done_s) next_state = ST_REQ;
            ST_REQ:  if (!done_s)          next_state = ST_ACK;
            ST_ACK:  if (done_s)           next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
        endcase
    end

    // SEND decodes straight from the state register so reset clears it at once.
    always_comb begin
        pop  = 1'b0;
        SEND = 1'b0;
        BUSY = 1'b0;
        case (state)
            ST_IDLE: pop = !EMPTY && done_s;
            ST_REQ: begin
                SEND = 1'b1;
                BUSY = 1'b1;
            end
            ST_ACK:  BUSY = 1'b1;
            default: BUSY = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx_feeder.sv
// Directed bench for serial_tx_feeder: scoreboard of queued bytes checked against
// what the transmitter model is offered, plus hand-timed flag and latency checks.
module tb_serial_tx_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic       BUSY;
    logic       SEND;
    logic [7:0] DATA;
    logic       DONE;

    logic       tx_auto = 1'b1;
    logic       done_model = 1'b1;
    logic       done_manual = 1'b1;
    int         tx_bits = 12;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic       send_prev = 1'b0;
    logic [7:0] held = 8'h00;

    assign DONE = tx_auto ? done_model : done_manual;

    serial_tx_feeder #(.DEPTH(16), .AW(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY),
        .SEND     (SEND),
        .DATA     (DATA),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_idle(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if (!BUSY && EMPTY && !SEND) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    // Writes consecutive bytes, one per edge; caller is aligned to a negedge.
    task automatic write_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = first + 8'(i);
            exp_q.push_back(first + 8'(i));
            @(negedge CLK);
        end
        WR_EN = 1'b0;
    endtask

    // Transmitter: accepts a byte two cycles after seeing SEND, busy for tx_bits cycles.
    always begin
        @(negedge CLK);
        if (tx_auto && SEND && done_model) begin
            repeat (2) @(negedge CLK);
            done_model = 1'b0;
            repeat (3) @(negedge CLK);
            check("send_fall_after_accept", 32'(SEND), 32'd0);
            repeat (tx_bits - 3) @(negedge CLK);
            done_model = 1'b1;
        end
    end

    // Scoreboard monitor: every SEND rise must present the next queued byte.
    always @(negedge CLK) begin
        if (SEND && !send_prev) begin
            check("send_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("tx_byte", 32'(DATA), 32'(exp_q.pop_front()));
            end
            held = DATA;
        end else if (SEND) begin
            check("data_stable", 32'(DATA), 32'(held));
        end
        send_prev = SEND;
    end

    initial begin
        do_reset();
        check("rst_send", 32'(SEND), 32'd0);
        check("rst_data", 32'(DATA), 32'h00);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);

        // Single byte
        WR_EN = 1'b1; WR_DATA = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge CLK);
        WR_EN = 1'b0;
        check("single_count_after_write", 32'(COUNT), 32'd1);
        check("single_send_not_yet", 32'(SEND), 32'd0);
        @(negedge CLK);
        check("single_send", 32'(SEND), 32'd1);
        check("single_data", 32'(DATA), 32'hA5);
        check("single_busy", 32'(BUSY), 32'd1);
        check("single_count_popped", 32'(COUNT), 32'd0);
        wait_idle(200);
        check("single_empty_end", 32'(EMPTY), 32'd1);
        check("single_busy_end", 32'(BUSY), 32'd0);

        // Burst of 16: one byte popped by the time the 16th lands
        write_burst(8'h01, 16);
        check("burst_count", 32'(COUNT), 32'd15);
        check("burst_full", 32'(FULL), 32'd0);
        wait_idle(1000);

        // Overflow with transmitter held busy
        tx_auto = 1'b0; done_manual = 1'b0;
        repeat (3) @(negedge CLK);
        write_burst(8'h20, 16);
        check("ovf_count_full", 32'(COUNT), 32'd16);
        check("ovf_full", 32'(FULL), 32'd1);
        check("ovf_no_send", 32'(SEND), 32'd0);
        WR_EN = 1'b1; WR_DATA = 8'hFF;
        @(negedge CLK);
        WR_EN = 1'b0;
        check("ovf_pulse", 32'(OVERFLOW), 32'd1);
        check("ovf_count_held", 32'(COUNT), 32'd16);
        @(negedge CLK);
        check("ovf_pulse_end", 32'(OVERFLOW), 32'd0);
        check("ovf_count_still", 32'(COUNT), 32'd16);
        tx_auto = 1'b1;
        wait_idle(1000);

        // Stuck transmitter after reset
        tx_auto = 1'b0; done_manual = 1'b0;
        do_reset();
        repeat (2) @(negedge CLK);
        WR_EN = 1'b1; WR_DATA = 8'h3C; exp_q.push_back(8'h3C);
        @(negedge CLK);
        WR_EN = 1'b0;
        repeat (5) @(negedge CLK);
        check("stuck_no_send", 32'(SEND), 32'd0);
        check("stuck_count", 32'(COUNT), 32'd1);
        check("stuck_not_busy", 32'(BUSY), 32'd0);
        done_manual = 1'b1;
        repeat (3) @(negedge CLK);
        check("stuck_release_send", 32'(SEND), 32'd1);
        check("stuck_release_data", 32'(DATA), 32'h3C);
        tx_auto = 1'b1;
        wait_idle(200);

        // Reset while in REQ with 5 bytes queued
        tx_auto = 1'b0; done_manual = 1'b1;
        write_burst(8'h51, 6);
        check("midrst_count", 32'(COUNT), 32'd5);
        check("midrst_in_req", 32'(SEND), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("midrst_send_drop", 32'(SEND), 32'd0);
        check("midrst_count_clr", 32'(COUNT), 32'd0);
        check("midrst_empty", 32'(EMPTY), 32'd1);
        exp_q.delete();
        done_manual = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        WR_EN = 1'b1; WR_DATA = 8'h77; exp_q.push_back(8'h77);
        @(negedge CLK);
        WR_EN = 1'b0;
        repeat (5) @(negedge CLK);
        check("midrst_wait_done", 32'(SEND), 32'd0);
        check("midrst_count_one", 32'(COUNT), 32'd1);
        done_manual = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_send_77", 32'(SEND), 32'd1);
        check("midrst_data_77", 32'(DATA), 32'h77);
        tx_auto = 1'b1;
        wait_idle(200);

        // Push and pop on the same edge with COUNT=3
        tx_auto = 1'b0; done_manual = 1'b0;
        repeat (3) @(negedge CLK);
        write_burst(8'h61, 3);
        check("pp_count_before", 32'(COUNT), 32'd3);
        check("pp_idle_before", 32'(SEND), 32'd0);
        done_manual = 1'b1;
        repeat (2) @(negedge CLK);
        WR_EN = 1'b1; WR_DATA = 8'h64; exp_q.push_back(8'h64);
        @(negedge CLK);
        WR_EN = 1'b0;
        check("pp_count_same", 32'(COUNT), 32'd3);
        check("pp_send", 32'(SEND), 32'd1);
        check("pp_data_head", 32'(DATA), 32'h61);
        tx_auto = 1'b1;
        wait_idle(500);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
